alu_accumulator: RTL and testbench

Sequential accumulator stage that wraps the combinational ripple-carry ALU. Accepts one command at a time over a valid/ready handshake. Drives registered operands and control into the ALU, then captures the ALU result and status (f, cout, v) into an accumulator and flag register. It is the state-holding stage directly downstream of the ALU, and the only writer of the accumulator and flags.

---
 rtl/alu_pkg.sv | 20 ++
 rtl/alu_flag_unit.sv | 46 ++++
 rtl/alu_accumulator.sv | 101 ++++++++++
 tb/tb_alu_accumulator.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the accumulator stage and its flag unit.
// Saturating capture is enabled by defining ALU_SAT_EN.
package alu_pkg;

   localparam int CNTRL_W = 3;

   // Bit positions inside the packed flag vector.
   localparam int FLAG_Z = 0;
   localparam int FLAG_N = 1;
   localparam int FLAG_C = 2;
   localparam int FLAG_V = 3;
   localparam int FLAG_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
   } alu_state_e;

endpackage

// File: rtl/alu_flag_unit.sv
// Combinational next-value logic for the accumulator and its status flags.
// Defining ALU_SAT_EN clamps overflowing arithmetic results to max/min.
module alu_flag_unit
   import alu_pkg::*;
#(
   parameter int N = 4
) (
   input  logic [N-1:0]      alu_f,
   input  logic              alu_cout,
   input  logic              alu_v,
   input  logic              load,
   input  logic [N-1:0]      load_value,
   output logic [N-1:0]      acc_next,
   output logic [FLAG_W-1:0] flags_next
);

   logic [N-1:0] result;

   always_comb begin
      result = alu_f;
      if (load) begin
         result = load_value;
      end
`ifdef ALU_SAT_EN
      // A wrapped negative sign bit means the true result overflowed upward.
      else if (alu_v) begin
         if (alu_f[N-1]) begin
            result = {1'b0, {(N-1){1'b1}}};
         end else begin
            result = {1'b1, {(N-1){1'b0}}};
         end
      end
`endif
   end

   always_comb begin
      flags_next         = '0;
      flags_next[FLAG_Z] = (result == '0);
      flags_next[FLAG_N] = result[N-1];
      flags_next[FLAG_C] = load ? 1'b0 : alu_cout;
      flags_next[FLAG_V] = load ? 1'b0 : alu_v;
   end

   assign acc_next = result;

endmodule

// File: rtl/alu_accumulator.sv
// Accumulator stage downstream of the ripple-carry ALU: IDLE -> EXEC -> DONE.
// Saturating capture is selected with the ALU_SAT_EN macro (see alu_flag_unit).
module alu_accumulator
   import alu_pkg::*;
#(
   parameter int N = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [CNTRL_W-1:0] cmd_op,
   input  logic               cmd_load,
   input  logic [N-1:0]       cmd_operand,
   output logic [N-1:0]       alu_a,
   output logic [N-1:0]       alu_b,
   output logic [CNTRL_W-1:0] alu_cntrl,
   input  logic [N-1:0]       alu_f,
   input  logic               alu_cout,
   input  logic               alu_v,
   output logic [N-1:0]       acc,
   output logic               flag_z,
   output logic               flag_n,
   output logic               flag_c,
   output logic               flag_v,
   output logic               res_valid
);

   alu_state_e         state_reg;
   alu_state_e         state_next;
   logic [N-1:0]       alu_b_reg;
   logic [CNTRL_W-1:0] alu_cntrl_reg;
   logic               load_reg;
   logic [N-1:0]       acc_reg;
   logic [FLAG_W-1:0]  flags_reg;
   logic               res_valid_reg;
   logic [N-1:0]       acc_next;
   logic [FLAG_W-1:0]  flags_next;
   logic               accept;

   assign accept = (state_reg == IDLE) && cmd_valid;

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (cmd_valid) state_next = EXEC;
         EXEC:    state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   alu_flag_unit #(
      .N(N)
   ) u_flag_unit (
      .alu_f      (alu_f),
      .alu_cout   (alu_cout),
      .alu_v      (alu_v),
      .load       (load_reg),
      .load_value (alu_b_reg),
      .acc_next   (acc_next),
      .flags_next (flags_next)
   );

   // An asynchronous reset during EXEC discards the command before capture.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         alu_b_reg     <= '0;
         alu_cntrl_reg <= '0;
         load_reg      <= 1'b0;
         acc_reg       <= '0;
         flags_reg     <= '0;
         res_valid_reg <= 1'b0;
      end else begin
         state_reg     <= state_next;
         res_valid_reg <= (state_reg == EXEC);
         if (accept) begin
            alu_b_reg     <= cmd_operand;
            alu_cntrl_reg <= cmd_op;
            load_reg      <= cmd_load;
         end
         if (state_reg == EXEC) begin
            acc_reg   <= acc_next;
            flags_reg <= flags_next;
         end
      end
   end

   assign cmd_ready = (state_reg == IDLE);
   assign alu_a     = acc_reg;
   assign alu_b     = alu_b_reg;
   assign alu_cntrl = alu_cntrl_reg;
   assign acc       = acc_reg;
   assign flag_z    = flags_reg[FLAG_Z];
   assign flag_n    = flags_reg[FLAG_N];
   assign flag_c    = flags_reg[FLAG_C];
   assign flag_v    = flags_reg[FLAG_V];
   assign res_valid = res_valid_reg;

endmodule

// File: tb/tb_alu_accumulator.sv
// Self-checking bench for alu_accumulator with an adder ALU stub (N=4).
// Expected saturation behaviour follows the ALU_SAT_EN macro.
module tb_alu_accumulator;

   logic       clk;
   logic       rst_n;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [2:0] cmd_op;
   logic       cmd_load;
   logic [3:0] cmd_operand;
   logic [3:0] alu_a;
   logic [3:0] alu_b;
   logic [2:0] alu_cntrl;
   logic [3:0] alu_f;
   logic       alu_cout;
   logic       alu_v;
   logic [3:0] acc;
   logic       flag_z;
   logic       flag_n;
   logic       flag_c;
   logic       flag_v;
   logic       res_valid;

   int total = 0;
   int bad   = 0;

   // Reference state, kept as plain integers.
   int m_acc = 0;
   bit m_z = 0, m_n = 0, m_c = 0, m_v = 0;

   alu_accumulator #(.N(4)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_op      (cmd_op),
      .cmd_load    (cmd_load),
      .cmd_operand (cmd_operand),
      .alu_a       (alu_a),
      .alu_b       (alu_b),
      .alu_cntrl   (alu_cntrl),
      .alu_f       (alu_f),
      .alu_cout    (alu_cout),
      .alu_v       (alu_v),
      .acc         (acc),
      .flag_z      (flag_z),
      .flag_n      (flag_n),
      .flag_c      (flag_c),
      .flag_v      (flag_v),
      .res_valid   (res_valid)
   );

   // ALU stub: 4-bit add with carry out and two's-complement overflow.
   assign {alu_cout, alu_f} = {1'b0, alu_a} + {1'b0, alu_b};
   assign alu_v = (alu_a[3] == alu_b[3]) && (alu_f[3] != alu_a[3]);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic model_apply(input bit load, input int operand);
      int sum, sa, sb, ss;
      if (load) begin
         m_acc = operand;
         m_c   = 0;
         m_v   = 0;
      end else begin
         sum = m_acc + operand;
         sa  = (m_acc > 7) ? m_acc - 16 : m_acc;
         sb  = (operand > 7) ? operand - 16 : operand;
         ss  = sa + sb;
         m_c = (sum > 15);
         m_v = (ss > 7) || (ss < -8);
         m_acc = sum % 16;
`ifdef ALU_SAT_EN
         if (m_v) m_acc = (ss > 7) ? 7 : 8;
`endif
      end
      m_z = (m_acc == 0);
      m_n = (m_acc >= 8);
   endtask

   // Issues one command from a negedge and checks the full 3-cycle transaction.
   task automatic do_cmd(input bit load, input logic [3:0] operand, input string tag);
      int guard;
      logic [2:0] op;
      guard = 0;
      while (cmd_ready !== 1'b1 && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      total++;
      if (guard >= 20) begin
         bad++;
         $display("FAIL %s ready_timeout: cmd_ready=%b required=1", tag, cmd_ready);
         return;
      end
      op          = 3'($urandom_range(0, 7));
      cmd_valid   = 1'b1;
      cmd_load    = load;
      cmd_operand = operand;
      cmd_op      = op;
      model_apply(load, int'(operand));
      @(negedge clk);
      // Busy: scramble the command bus, which must be ignored.
      cmd_operand = 4'($urandom);
      cmd_load    = 1'($urandom);
      cmd_op      = 3'($urandom);
      total++;
      if (cmd_ready !== 1'b0 || res_valid !== 1'b0) begin
         bad++;
         $display("FAIL %s exec_handshake: ready=%b res_valid=%b required 0 0", tag, cmd_ready, res_valid);
      end
      total++;
      if (alu_b !== operand || alu_cntrl !== op) begin
         bad++;
         $display("FAIL %s alu_inputs: alu_b=%h cntrl=%h required %h %h", tag, alu_b, alu_cntrl, operand, op);
      end
      @(negedge clk);
      cmd_valid = 1'b0;
      total++;
      if (res_valid !== 1'b1 || cmd_ready !== 1'b0) begin
         bad++;
         $display("FAIL %s done_handshake: res_valid=%b ready=%b required 1 0", tag, res_valid, cmd_ready);
      end
      total++;
      if (acc !== 4'(m_acc) || alu_a !== 4'(m_acc)) begin
         bad++;
         $display("FAIL %s acc: acc=%h alu_a=%h required %h", tag, acc, alu_a, 4'(m_acc));
      end
      total++;
      if ({flag_z, flag_n, flag_c, flag_v} !== {m_z, m_n, m_c, m_v}) begin
         bad++;
         $display("FAIL %s flags: zncv=%b%b%b%b required %b%b%b%b", tag,
                  flag_z, flag_n, flag_c, flag_v, m_z, m_n, m_c, m_v);
      end
      @(negedge clk);
      total++;
      if (res_valid !== 1'b0 || cmd_ready !== 1'b1) begin
         bad++;
         $display("FAIL %s idle_return: res_valid=%b ready=%b required 0 1", tag, res_valid, cmd_ready);
      end
      $display("cmd %s load=%0d operand=%h op=%0d acc=%h zncv=%b%b%b%b", tag, load, operand, op,
               acc, flag_z, flag_n, flag_c, flag_v);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      cmd_valid = 1'b0; cmd_load = 1'b0; cmd_op = 3'd0; cmd_operand = 4'd0;
      repeat (3) @(negedge clk);
      total++;
      if (acc !== 4'h0 || {flag_z, flag_n, flag_c, flag_v} !== 4'b0000 || res_valid !== 1'b0) begin
         bad++;
         $display("FAIL reset_state: acc=%h zncv=%b%b%b%b res_valid=%b required 0 0000 0",
                  acc, flag_z, flag_n, flag_c, flag_v, res_valid);
      end
      rst_n = 1'b1;
      @(negedge clk);
      total++;
      if (cmd_ready !== 1'b1 || alu_b !== 4'h0 || alu_cntrl !== 3'h0) begin
         bad++;
         $display("FAIL reset_release: ready=%b alu_b=%h cntrl=%h required 1 0 0", cmd_ready, alu_b, alu_cntrl);
      end
      $display("reset done acc=%h ready=%b", acc, cmd_ready);
      m_acc = 0; m_z = 0; m_n = 0; m_c = 0; m_v = 0;
   endtask

   task automatic test_reset_mid_exec();
      bit saw_valid;
      do_cmd(1'b1, 4'h5, "reset_pre_load");
      cmd_valid = 1'b1; cmd_load = 1'b0; cmd_operand = 4'h3; cmd_op = 3'd0;
      @(negedge clk);
      cmd_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      total++;
      if (acc !== 4'h0 || {flag_z, flag_n, flag_c, flag_v} !== 4'b0000) begin
         bad++;
         $display("FAIL mid_exec_reset_clear: acc=%h zncv=%b%b%b%b required 0 0000",
                  acc, flag_z, flag_n, flag_c, flag_v);
      end
      @(negedge clk);
      rst_n = 1'b1;
      saw_valid = 0;
      repeat (3) begin
         @(negedge clk);
         if (res_valid !== 1'b0) saw_valid = 1;
      end
      total++;
      if (saw_valid || acc !== 4'h0 || cmd_ready !== 1'b1) begin
         bad++;
         $display("FAIL mid_exec_reset_after: saw_res_valid=%0d acc=%h ready=%b required 0 0 1",
                  saw_valid, acc, cmd_ready);
      end
      $display("reset mid-exec acc=%h ready=%b", acc, cmd_ready);
      m_acc = 0; m_z = 0; m_n = 0; m_c = 0; m_v = 0;
   endtask

   task automatic test_load_zero();
      do_cmd(1'b1, 4'h0, "load_zero");
      total++;
      if (acc !== 4'h0 || {flag_z, flag_n, flag_c, flag_v} !== 4'b1000) begin
         bad++;
         $display("FAIL load_zero_const: acc=%h zncv=%b%b%b%b required 0 1000", acc, flag_z, flag_n, flag_c, flag_v);
      end
   endtask

   task automatic test_add_carry();
      do_cmd(1'b1, 4'hF, "carry_load");
      do_cmd(1'b0, 4'h1, "carry_add");
      total++;
      if (acc !== 4'h0 || {flag_z, flag_n, flag_c, flag_v} !== 4'b1010) begin
         bad++;
         $display("FAIL add_carry_const: acc=%h zncv=%b%b%b%b required 0 1010", acc, flag_z, flag_n, flag_c, flag_v);
      end
   endtask

   task automatic test_overflow();
      logic [3:0] want_acc;
      logic       want_n;
`ifdef ALU_SAT_EN
      want_acc = 4'h7; want_n = 1'b0;
`else
      want_acc = 4'h8; want_n = 1'b1;
`endif
      do_cmd(1'b1, 4'h7, "ovf_load");
      do_cmd(1'b0, 4'h1, "ovf_add");
      total++;
      if (acc !== want_acc || flag_n !== want_n || flag_v !== 1'b1) begin
         bad++;
         $display("FAIL overflow_const: acc=%h n=%b v=%b required %h %b 1", acc, flag_n, flag_v, want_acc, want_n);
      end
      do_cmd(1'b1, 4'h8, "neg_ovf_load");
      do_cmd(1'b0, 4'hF, "neg_ovf_add");
   endtask

   task automatic test_random();
      for (int i = 0; i < 24; i++) begin
         do_cmd(($urandom_range(0, 3) == 0), 4'($urandom), "random");
      end
   endtask

   task automatic test_back_to_back();
      int busy;
      int guard;
      logic [3:0] op2;
      do_cmd(1'b1, 4'h2, "b2b_seed");
      // First command accepted at the next edge; valid stays high throughout.
      cmd_valid = 1'b1; cmd_load = 1'b0; cmd_operand = 4'h6; cmd_op = 3'd1;
      model_apply(1'b0, 6);
      @(negedge clk);
      busy = 0;
      guard = 0;
      while (cmd_ready !== 1'b1 && guard < 10) begin
         busy++;
         cmd_operand = 4'($urandom);
         if (res_valid === 1'b1) begin
            total++;
            if (acc !== 4'(m_acc)) begin
               bad++;
               $display("FAIL b2b_first_acc: acc=%h required %h", acc, 4'(m_acc));
            end
         end
         @(negedge clk);
         guard++;
      end
      total++;
      if (busy != 2) begin
         bad++;
         $display("FAIL b2b_busy_cycles: busy=%0d required 2", busy);
      end
      op2 = 4'($urandom);
      cmd_operand = op2; cmd_load = 1'b0;
      model_apply(1'b0, int'(op2));
      @(negedge clk);
      total++;
      if (cmd_ready !== 1'b0 || alu_b !== op2) begin
         bad++;
         $display("FAIL b2b_second_accept: ready=%b alu_b=%h required 0 %h", cmd_ready, alu_b, op2);
      end
      cmd_valid = 1'b0;
      @(negedge clk);
      total++;
      if (res_valid !== 1'b1 || acc !== 4'(m_acc)) begin
         bad++;
         $display("FAIL b2b_second_result: res_valid=%b acc=%h required 1 %h", res_valid, acc, 4'(m_acc));
      end
      $display("cmd b2b second operand=%h acc=%h", op2, acc);
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_reset_mid_exec();
      test_load_zero();
      test_add_carry();
      test_overflow();
      test_random();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
